// File: rtl/mips_reg_file.sv
// rtl/mips_reg_file.sv - 32x32 MIPS register file, 2 comb read ports, 1 sync write port (option: REGFILE_WR_BYPASS_EN)
module mips_reg_file #(
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          ADDR_W    = 5,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_sel;
    logic                byp_ok;

    // One-hot demux of the write select; nothing is indexed when wr_en is low,
    // so an X address or data cannot leak into the array.
    always_comb begin
        wr_sel = '0;
        if (wr_en) begin
            wr_sel[wr_addr] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_sel[i]) begin
                regs_d[i] = wr_data;
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef REGFILE_WR_BYPASS_EN
    assign byp_ok = rst_n && wr_en && (wr_addr != '0);
`else
    assign byp_ok = 1'b0;
`endif

    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        if (byp_ok && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end
        if (rd_addr1 == '0) begin
            rd_data1 = '0;
        end
    end

    always_comb begin
        rd_data2 = regs_q[rd_addr2];
        if (byp_ok && (rd_addr2 == wr_addr)) begin
            rd_data2 = wr_data;
        end
        if (rd_addr2 == '0) begin
            rd_data2 = '0;
        end
    end

    always_comb begin
        dbg_data = regs_q[dbg_addr];
        if (byp_ok && (dbg_addr == wr_addr)) begin
            dbg_data = wr_data;
        end
        if (dbg_addr == '0) begin
            dbg_data = '0;
        end
    end

endmodule

// File: tb/tb_mips_reg_file.sv
// tb/tb_mips_reg_file.sv - self-checking bench for mips_reg_file
module tb_mips_reg_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, dbg_addr;
    logic [31:0] rd_data1, rd_data2, dbg_data;
    logic [31:0] b_rd_data1, b_rd_data2, b_dbg_data;
    logic        wr_en;
    logic [31:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [6];

    mips_reg_file dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    mips_reg_file #(.RESET_VAL(32'hDEAD_BEEF)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(rd_addr1), .rd_data1(b_rd_data1),
        .rd_addr2(rd_addr2), .rd_data2(b_rd_data2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_data(b_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: a register is an array slot; $zero reads 0; forwarding only when enabled.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_WR_BYPASS_EN
        if (rst_n === 1'b1 && wr_en === 1'b1 && wr_addr != 5'd0 && wr_addr == a) return wr_data;
`endif
        return model[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic step();
        logic        do_w;
        logic [4:0]  a;
        logic [31:0] d;
        do_w = (rst_n === 1'b1) && (wr_en === 1'b1) && (wr_addr != 5'd0);
        a = wr_addr;
        d = wr_data;
        @(posedge clk);
        if (do_w === 1'b1) model[a] = d;
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd1,  32'h0000_0000, 32'h1000_0001};
        vecs[1] = '{1'b0, 5'd7,  32'h1234_5678, 5'd7,  5'd6,  32'h1000_0007, 32'h1000_0006};
        vecs[2] = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd30, 32'hCAFE_F00D, 32'h1000_001E};
        vecs[3] = '{1'b1, 5'd1,  32'h0BAD_0001, 5'd1,  5'd31, 32'h0BAD_0001, 32'hCAFE_F00D};
        vecs[4] = '{1'b0, 'x,    'x,            5'd31, 5'd1,  32'hCAFE_F00D, 32'h0BAD_0001};
        vecs[5] = '{1'b1, 5'd5,  32'hAAAA_AAAA, 5'd5,  5'd5,  32'hAAAA_AAAA, 32'hAAAA_AAAA};

        rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h3333_3333;
        rd_addr1 = 5'd0; rd_addr2 = 5'd0; dbg_addr = 5'd0;
        model_reset();
        #2;
        step();
        step();
        wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); rd_addr1 = 5'(i);
            #1;
            check("reset_dbg_rv0", dbg_data, 32'h0);
            check("reset_dbg_rvdb", b_dbg_data, (i == 0) ? 32'h0 : 32'hDEAD_BEEF);
            check("reset_rd1_rvdb", b_rd_data1, (i == 0) ? 32'h0 : 32'hDEAD_BEEF);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h1000_0000 + 32'(i);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
            #1;
            check("pair_rd1", rd_data1, (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i));
            check("pair_rd2", rd_data2, (i == 31) ? 32'h0 : 32'h1000_0000 + 32'(31 - i));
        end

        for (int v = 0; v < 6; v++) begin
            wr_en = vecs[v].we; wr_addr = vecs[v].wa; wr_data = vecs[v].wd;
            rd_addr1 = vecs[v].ra1; rd_addr2 = vecs[v].ra2;
            step();
            check($sformatf("vec%0d_rd1", v), rd_data1, vecs[v].exp1);
            check($sformatf("vec%0d_rd2", v), rd_data2, vecs[v].exp2);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            check("sweep_dbg", dbg_data, exp_rd(5'(i)));
        end

        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h5555_5555; rd_addr1 = 5'd5; dbg_addr = 5'd5;
        #2;
`ifdef REGFILE_WR_BYPASS_EN
        check("rdw_pre_rd1", rd_data1, 32'h5555_5555);
        check("rdw_pre_dbg", dbg_data, 32'h5555_5555);
`else
        check("rdw_pre_rd1", rd_data1, 32'hAAAA_AAAA);
        check("rdw_pre_dbg", dbg_data, 32'hAAAA_AAAA);
`endif
        step();
        wr_en = 1'b0;
        #1;
        check("rdw_post_rd1", rd_data1, 32'h5555_5555);

        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9999_9999;
        rd_addr1 = 5'd9; rd_addr2 = 5'd31; dbg_addr = 5'd9;
        #1;
        check("midrst_before_dbg", dbg_data, exp_rd(5'd9));
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_rd1", rd_data1, 32'h0);
        check("midrst_dbg", dbg_data, 32'h0);
        check("midrst_b_dbg", b_dbg_data, 32'hDEAD_BEEF);
        step();
        check("midrst_edge_rd1", rd_data1, 32'h0);
        check("midrst_edge_b_rd1", b_rd_data1, 32'hDEAD_BEEF);
        #2;
        rst_n = 1'b1;
        #1;
        check("release_pre_rd1", rd_data1, exp_rd(5'd9));
        step();
        check("release_post_rd1", rd_data1, 32'h9999_9999);
        check("release_post_rd2", rd_data2, 32'h0);

        for (int n = 0; n < 400; n++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            wr_data  = $urandom;
            rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            rd_addr2 = 5'($urandom);
            dbg_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            #2;
            check("rand_rd1", rd_data1, exp_rd(rd_addr1));
            check("rand_rd2", rd_data2, exp_rd(rd_addr2));
            check("rand_dbg", dbg_data, exp_rd(dbg_addr));
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            check("final_dbg", dbg_data, exp_rd(5'(i)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
